// File: rtl/vga_rx_pkg.sv
// Shared FSM type and default 640x480 timing for the VGA receive decoder.
package vga_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam bit DEF_SYNC_ACTIVE_LOW = 1'b1;

    function automatic int timing_total(input int sync_len, input int back_len,
                                        input int active_len, input int front_len);
        return sync_len + back_len + active_len + front_len;
    endfunction

    localparam int DEF_H_TOTAL = timing_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_ACTIVE, DEF_H_FRONT);
    localparam int DEF_V_TOTAL = timing_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_ACTIVE, DEF_V_FRONT);
    localparam int DEF_H_START = DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_START = DEF_V_SYNC + DEF_V_BACK;

endpackage

// File: rtl/vga_rx_crc16.sv
// Byte-per-clock CRC-16-CCITT (poly 0x1021, seed 0xFFFF) over the decoded pixel stream.
module vga_rx_crc16 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        valid_i,
    input  logic        last_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o,
    output logic        crc_valid_o
);

    function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    logic [15:0] crc_reg;
    logic        crc_valid_reg;

    // The first pixel of a frame is folded into a fresh seed rather than the old value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_reg       <= '0;
            crc_valid_reg <= 1'b0;
        end else begin
            if (valid_i) begin
                crc_reg <= crc_step(init_i ? 16'hFFFF : crc_reg, data_i);
            end
            crc_valid_reg <= valid_i && last_i;
        end
    end

    assign crc_o       = crc_reg;
    assign crc_valid_o = crc_valid_reg;

endmodule

// File: rtl/vga_rx_decoder.sv
// Locks to VGA sync timing and recovers pixel coordinates with a 2-clock latency.
// Optional frame CRC outputs are built when VGA_RX_CRC_EN is defined.
module vga_rx_decoder
    import vga_rx_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter bit SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  rrggbb_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    output logic [5:0]  rrggbb_o,
    output logic [9:0]  x_o,
    output logic [8:0]  y_o,
    output logic        pixel_valid_o,
    output logic        frame_start_o,
    output logic        locked_o,
    output logic        error_o
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0] crc_o,
    output logic        crc_valid_o
`endif
);

    localparam int H_TOTAL = timing_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int V_TOTAL = timing_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SAT   = HW'(H_TOTAL);
    localparam logic [HW-1:0] H_FIRST = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_END   = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SAT   = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_FIRST = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_END   = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);

    logic [5:0]    s1_rgb_reg;
    logic          s1_hs_reg, s1_vs_reg, s1_hs_prev_reg, s1_vs_prev_reg;
    logic [HW-1:0] hcount_reg, hcount_next;
    logic [VW-1:0] vcount_reg, vcount_next;
    logic          vsync_pending_reg, vsync_pending_next;
    rx_state_t     state_reg;
    logic          hs_edge, vs_edge, line0, mismatch, lock_next, valid_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_rgb_reg     <= '0;
            s1_hs_reg      <= 1'b0;
            s1_vs_reg      <= 1'b0;
            s1_hs_prev_reg <= 1'b0;
            s1_vs_prev_reg <= 1'b0;
        end else begin
            s1_rgb_reg     <= rrggbb_i;
            s1_hs_reg      <= hsync_i ^ SYNC_ACTIVE_LOW;
            s1_vs_reg      <= vsync_i ^ SYNC_ACTIVE_LOW;
            s1_hs_prev_reg <= s1_hs_reg;
            s1_vs_prev_reg <= s1_vs_reg;
        end
    end

    // Counters are evaluated for the sample now in stage 1, so stage 2 can register them directly.
    always_comb begin
        hs_edge  = s1_hs_reg & ~s1_hs_prev_reg;
        vs_edge  = s1_vs_reg & ~s1_vs_prev_reg;
        line0    = hs_edge & (vsync_pending_reg | vs_edge);
        mismatch = (hs_edge & (hcount_reg != H_LAST)) | (line0 & (vcount_reg != V_LAST));

        hcount_next = hcount_reg;
        if (hs_edge) begin
            hcount_next = '0;
        end else if (hcount_reg != H_SAT) begin
            hcount_next = hcount_reg + 1'b1;
        end

        vcount_next = vcount_reg;
        if (line0) begin
            vcount_next = '0;
        end else if (hs_edge && vcount_reg != V_SAT) begin
            vcount_next = vcount_reg + 1'b1;
        end

        vsync_pending_next = vsync_pending_reg;
        if (line0) begin
            vsync_pending_next = 1'b0;
        end else if (vs_edge) begin
            vsync_pending_next = 1'b1;
        end

        lock_next  = !mismatch && ((state_reg == LOCKED) || (state_reg == ALIGN && line0));
        valid_next = lock_next
                     && (hcount_next >= H_FIRST) && (hcount_next <= H_END)
                     && (vcount_next >= V_FIRST) && (vcount_next <= V_END);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcount_reg        <= '0;
            vcount_reg        <= '0;
            vsync_pending_reg <= 1'b0;
        end else begin
            hcount_reg        <= hcount_next;
            vcount_reg        <= vcount_next;
            vsync_pending_reg <= vsync_pending_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= SEARCH;
            rrggbb_o      <= '0;
            x_o           <= '0;
            y_o           <= '0;
            pixel_valid_o <= 1'b0;
            frame_start_o <= 1'b0;
            locked_o      <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            error_o <= 1'b0;
            case (state_reg)
                SEARCH: begin
                    if (line0) state_reg <= ALIGN;
                end
                ALIGN: begin
                    if (mismatch) begin
                        state_reg <= SEARCH;
                        error_o   <= 1'b1;
                    end else if (line0) begin
                        state_reg <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        state_reg <= SEARCH;
                        error_o   <= 1'b1;
                    end
                end
                default: state_reg <= SEARCH;
            endcase
            locked_o      <= lock_next;
            pixel_valid_o <= valid_next;
            rrggbb_o      <= s1_rgb_reg;
            x_o           <= valid_next ? 10'(hcount_next - H_FIRST) : '0;
            y_o           <= valid_next ? 9'(vcount_next - V_FIRST) : '0;
            frame_start_o <= valid_next && (hcount_next == H_FIRST) && (vcount_next == V_FIRST);
        end
    end

`ifdef VGA_RX_CRC_EN
    logic crc_last;
    assign crc_last = (x_o == 10'(H_ACTIVE - 1)) && (y_o == 9'(V_ACTIVE - 1));

    vga_rx_crc16 u_crc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .init_i      (frame_start_o),
        .valid_i     (pixel_valid_o),
        .last_i      (crc_last),
        .data_i      ({2'b00, rrggbb_o}),
        .crc_o       (crc_o),
        .crc_valid_o (crc_valid_o)
    );
`endif

endmodule
